// File: rtl/aes_sched.sv
// aes_sched: round-robin scheduler sharing one aes_core among N_REQ requesters
// Optional watchdog abort on a stuck core: define AES_SCHED_TIMEOUT_EN
module aes_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       enc_in,
  input  logic [2*N_REQ-1:0]     aes_len_in,
  input  logic [256*N_REQ-1:0]   key_in,
  input  logic [128*N_REQ-1:0]   pt_in,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       done,
  output logic [127:0]           ct_out,
  output logic                   err,
  output logic                   busy,
  output logic [ID_W-1:0]        cur_id,
  output logic                   core_rst,
  output logic                   core_enc,
  output logic [1:0]             core_aes_len,
  output logic [255:0]           core_key,
  output logic [127:0]           core_pt,
  input  logic [127:0]           core_ct,
  input  logic                   core_valid
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state;
  logic [ID_W-1:0] ptr, pick, sel;
  logic timeout;
`ifdef AES_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  assign timeout = cnt == CW'(TIMEOUT_CYC - 1);
`else
  assign timeout = TIMEOUT_CYC < 0;
`endif
  // Scan downward so the lowest offset from ptr is the last (winning) assignment
  always_comb begin
    pick = '0;
    sel = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sel = ID_W'((int'(ptr) + k) % N_REQ);
      if (req[sel]) pick = sel;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      ack <= '0;
      done <= '0;
      ct_out <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      cur_id <= '0;
      core_rst <= 1'b1;
      core_enc <= 1'b0;
      core_aes_len <= '0;
      core_key <= '0;
      core_pt <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      ack <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          core_rst <= 1'b1;
          if (|req) begin
            cur_id <= pick;
            busy <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          core_enc <= enc_in[cur_id];
          core_aes_len <= aes_len_in[{cur_id, 1'b0} +: 2];
          core_key <= key_in[{cur_id, 8'd0} +: 256];
          core_pt <= pt_in[{cur_id, 7'd0} +: 128];
          ack <= N_REQ'(1) << cur_id;
          ptr <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
`ifdef AES_SCHED_TIMEOUT_EN
          cnt <= '0;
`endif
          state <= RUN;
        end
        RUN: begin
          core_rst <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
          cnt <= cnt + CW'(1);
`endif
          // A result arriving on the limit cycle still counts as a good result
          if (core_valid || timeout) begin
            ct_out <= core_valid ? core_ct : '0;
            err <= !core_valid;
            done <= N_REQ'(1) << cur_id;
            core_rst <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_sched.sv
// tb_aes_sched: randomized and directed checks of aes_sched against a job-level model
module tb_aes_sched;
  localparam int N = 4;
  localparam int IW = 2;
`ifdef AES_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [255:0] KAT_K = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_C = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0, enc_in = '0;
  logic [2*N-1:0] aes_len_in = '0;
  logic [256*N-1:0] key_in = '0;
  logic [128*N-1:0] pt_in = '0;
  logic [N-1:0] ack, done;
  logic [127:0] ct_out, core_pt;
  logic err, busy, core_rst, core_enc;
  logic [IW-1:0] cur_id;
  logic [1:0] core_aes_len;
  logic [255:0] core_key;
  logic [127:0] core_ct = '0;
  logic core_valid = 0;
  int lat = 0;
  bit stall = 0;

  aes_sched #(.N_REQ(N), .ID_W(IW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .enc_in(enc_in), .aes_len_in(aes_len_in),
    .key_in(key_in), .pt_in(pt_in), .ack(ack), .done(done), .ct_out(ct_out),
    .err(err), .busy(busy), .cur_id(cur_id), .core_rst(core_rst), .core_enc(core_enc),
    .core_aes_len(core_aes_len), .core_key(core_key), .core_pt(core_pt),
    .core_ct(core_ct), .core_valid(core_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stand-in core: known-answer vector for the FIPS-197 AES-256 case, a keyed mix otherwise
  function automatic logic [127:0] fcore(logic [255:0] k, logic [127:0] p, logic e, logic [1:0] l);
    if (k == KAT_K && p == KAT_P && e && l == 2'd2) return KAT_C;
    return k[255:128] ^ {k[126:0], k[127]} ^ (e ? p : ~p) ^ {126'd0, l};
  endfunction

  always @(posedge clk) begin
    if (core_rst) begin
      lat <= $urandom_range(1, 6);
      core_valid <= !busy && ($urandom_range(0, 3) == 0);
      core_ct <= {$urandom, $urandom, $urandom, $urandom};
    end else if (lat > 0) begin
      lat <= lat - 1;
      core_valid <= 1'b0;
    end else begin
      core_valid <= !stall;
      core_ct <= fcore(core_key, core_pt, core_enc, core_aes_len);
    end
  end

  logic [N-1:0] e_ack, e_done;
  logic [127:0] e_ct, e_pt;
  logic [255:0] e_key;
  logic [1:0] e_len;
  logic [IW-1:0] e_id;
  logic e_err, e_busy, e_rst, e_enc;
  bit primed = 0, m_busy = 0, m_loaded = 0;
  int m_id = 0, m_ptr = 0, m_run = 0;
  int glog[$];

  function automatic int rr(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic close(input logic [127:0] ct, input logic er);
    e_ct = ct;
    e_err = er;
    e_done = N'(1) << m_id;
    e_rst = 1;
    e_busy = 0;
    m_busy = 0;
  endtask

  // Inputs are stable from negedge to the next posedge, so the model steps here on what that edge samples
  initial forever begin
    @(negedge clk);
    if (primed) begin
      chk("ack", ack, e_ack);
      chk("done", done, e_done);
      chk("ct_out", ct_out, e_ct);
      chk("err", err, e_err);
      chk("busy", busy, e_busy);
      chk("cur_id", cur_id, e_id);
      chk("core_rst", core_rst, e_rst);
      chk("core_enc", core_enc, e_enc);
      chk("core_aes_len", core_aes_len, e_len);
      chk("core_key", core_key, e_key);
      chk("core_pt", core_pt, e_pt);
    end
    e_ack = '0;
    e_done = '0;
    if (rst) begin
      primed = 1;
      e_ct = '0; e_err = 0; e_busy = 0; e_id = '0; e_rst = 1;
      e_enc = 0; e_len = '0; e_key = '0; e_pt = '0;
      m_busy = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_id = rr(req, m_ptr);
        m_busy = 1;
        m_loaded = 0;
        e_busy = 1;
        e_id = IW'(m_id);
      end
    end else if (!m_loaded) begin
      e_enc = enc_in[m_id];
      e_len = aes_len_in[2*m_id +: 2];
      e_key = key_in[256*m_id +: 256];
      e_pt = pt_in[128*m_id +: 128];
      e_ack = N'(1) << m_id;
      m_ptr = (m_id + 1) % N;
      m_loaded = 1;
      m_run = 0;
      glog.push_back(m_id);
    end else begin
      m_run++;
      e_rst = 0;
      if (core_valid) close(fcore(e_key, e_pt, e_enc, e_len), 0);
`ifdef AES_SCHED_TIMEOUT_EN
      else if (m_run == TO) close('0, 1);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) tick();
    rst = 0;
  endtask

  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_ops(input int i, input logic [255:0] k, input logic [127:0] p, input logic e, input logic [1:0] l);
    key_in[256*i +: 256] = k;
    pt_in[128*i +: 128] = p;
    enc_in[i] = e;
    aes_len_in[2*i +: 2] = l;
  endtask

  task automatic rand_ops(input int i);
    logic [255:0] p;
    p = r256();
    set_ops(i, r256(), p[127:0], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)));
  endtask

  task automatic wait_pulse(input bit d, input int i, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = d ? done[i] : ack[i];
    end
    chk(d ? "wait_done" : "wait_ack", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      ok = !busy;
    end
    chk("wait_idle", ok, 1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, seen0;
    int n, bad;
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [255:0] ok_key;
    logic [127:0] ok_pt;
    logic ok_enc;
    logic [1:0] ok_len;
    for (int i = 0; i < N; i++) rand_ops(i);
    do_reset();
    @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    tick();

    set_ops(0, KAT_K, KAT_P, 1'b1, 2'd2);
    req = 4'b0001;
    tick();
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_ack_early", ack, 4'b0000);
    tick();
    req = 4'b0000;
    @(negedge clk);
    chk("t1_ack", ack, 4'b0001);
    chk("t1_core_held", core_rst, 1);
    tick();
    @(negedge clk);
    chk("t1_core_release", core_rst, 0);
    wait_pulse(1, 0, 40, ok);
    chk("t1_kat_ct", ct_out, KAT_C);
    chk("t1_err", err, 0);
    wait_idle();

    do_reset();
    for (int i = 0; i < N; i++) rand_ops(i);
    glog.delete();
    req = 4'b1111;
    n = 0;
    for (int c = 0; c < 400 && n < 8; c++) begin
      @(negedge clk);
      if (|done) begin
        n++;
        chk("t2_gap_idle", {busy, core_rst}, 2'b01);
      end
    end
    chk("t2_jobs", n, 8);
    tick();
    req = '0;
    wait_idle();
    chk("t2_grants", glog.size() >= 8, 1);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("t2_order", glog[i], exp_order[i]);

    req = 4'b0001;
    wait_pulse(0, 0, 20, ok);
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    bad = 0;
    seen0 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack[2] || done[2]) bad++;
      if (done[0]) seen0 = 1;
    end
    chk("t3_no_grant2", bad, 0);
    chk("t3_done0", seen0, 1);
    tick();

    rand_ops(1);
    ok_key = key_in[256 +: 256];
    ok_pt = pt_in[128 +: 128];
    ok_enc = enc_in[1];
    ok_len = aes_len_in[2 +: 2];
    req = 4'b0010;
    wait_pulse(0, 1, 20, ok);
    tick();
    rand_ops(1);
    req = 4'b0000;
    wait_pulse(1, 1, 40, ok);
    chk("t4_frozen_ct", ct_out, fcore(ok_key, ok_pt, ok_enc, ok_len));
    wait_idle();

    do_reset();
    req = 4'b1111;
    wait_pulse(0, 0, 20, ok);
    wait_pulse(0, 1, 40, ok);
    tick();
    tick();
    rst = 1;
    req = 4'b0000;
    tick();
    rst = 0;
    req = 4'b1010;
    @(negedge clk);
    chk("t5_core_rst", core_rst, 1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 4'b0000);
    wait_pulse(0, 1, 20, ok);
    chk("t5_cur_id", cur_id, 1);
    tick();
    req = 4'b0000;
    wait_idle();

`ifdef AES_SCHED_TIMEOUT_EN
    stall = 1;
    req = 4'b0001;
    wait_pulse(0, 0, 20, ok);
    tick();
    req = 4'b0000;
    n = 0;
    ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      n++;
      ok = done[0];
    end
    chk("t6_timeout_seen", ok, 1);
    chk("t6_run_cycles", n, 16);
    chk("t6_err", err, 1);
    chk("t6_ct_zero", ct_out, 128'd0);
    stall = 0;
    wait_idle();
`endif

    for (int i = 0; i < N; i++) rand_ops(i);
    repeat (1500) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          rand_ops(i);
          req[i] = 1'($urandom_range(0, 1));
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          rand_ops(i);
          req[i] = 1'b1;
        end
      end
    end
    rst = 0;
    req = '0;
    tick();
    wait_idle();
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
